// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writeback with buffered MDU results.
// Also exports a pending-write mask of registers still held in the MDU FIFO, for decode hazard checks.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        reg_write_en,
  output logic [31:0] busy_mask,
  output logic        pipe_stall
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t                   mem_q [FIFO_DEPTH];
  wr_t                   mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            starve_q, starve_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic empty, pipe_eff, enq, deq, pipe_sel;

  // Arbitration: a forced stall hands the port to the FIFO head and drops any pipeline write.
  always_comb begin
    empty      = (cnt_q == '0);
    mdu_ready  = (cnt_q != FULL_CNT);
    pipe_stall = (starve_q == LIMIT);
    pipe_eff   = pipe_we && (pipe_rd != 5'd0);
    enq        = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    deq        = 1'b0;
    pipe_sel   = 1'b0;
    if (pipe_stall && !empty) deq = 1'b1;
    else if (pipe_eff)        pipe_sel = 1'b1;
    else if (!empty)          deq = 1'b1;
  end

  always_comb begin
    mem_d   = mem_q;
    vld_d   = vld_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    // Enqueue never targets the head slot while dequeuing: that would require a full FIFO.
    if (deq) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    if (enq) begin
      mem_d[wptr_q] = '{rd: mdu_rd, data: mdu_data};
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (deq || empty)                        starve_d = '0;
    else if (pipe_sel && starve_q != LIMIT)  starve_d = starve_q + 8'd1;
    else                                     starve_d = starve_q;

    we_d    = deq || pipe_sel;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (deq) begin
      rd_d    = mem_q[rptr_q].rd;
      wdata_d = mem_q[rptr_q].data;
    end else if (pipe_sel) begin
      rd_d    = pipe_rd;
      wdata_d = pipe_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld_q[i]) busy_mask[mem_q[i].rd] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  assign rd           = rd_q;
  assign write_data   = wdata_q;
  assign reg_write_en = we_q;
endmodule
